// File: rtl/instr_fetch_q.sv
// instr_fetch_q: fetch stage with a small in-order fetch queue.
// The PC fetches one word per cycle into the queue while there is room, or
// when the head is leaving that same cycle. A branch or jump redirect
// flushes the queue and reloads the PC. Decode drains the queue from the head.
module instr_fetch_q #(
  parameter int          IMEM_AW  = 6,
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pc_src,
  input  logic [31:0]                   pc_branch,
  input  logic                          jump,
  input  logic [31:0]                   pc_jump,
  input  logic                          stall_id,
  output logic [IMEM_AW-1:0]            imem_addr,
  input  logic [31:0]                   imem_rdata,
  output logic                          if_id_valid,
  output logic [31:0]                   if_id_instr,
  output logic [31:0]                   if_id_pc_plus_4,
  output logic [$clog2(FQ_DEPTH):0]     fq_count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Queue storage holds the fetched word and the PC+4 that goes with it.
  logic [31:0] fq_instr_q [FQ_DEPTH];
  logic [31:0] fq_pc4_q   [FQ_DEPTH];

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus_4;
  logic        head_valid;
  logic        pop;
  logic        push;

  // Decide redirect, pop and push for this cycle and compute the next state.
  always_comb begin
    redirect   = pc_src | jump;
    target     = jump ? pc_jump : pc_branch;
    target     = {target[31:2], 2'b00};
    pc_plus_4  = pc_q + 32'd4;
    head_valid = (count_q != '0);
    pop        = head_valid & ~stall_id & ~redirect;
    push       = ~redirect & ((count_q < DEPTH_C) | pop);

    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (redirect) begin
      pc_d     = target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_plus_4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // PC, pointers and occupancy; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the fetched word at the tail; storage contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fq_instr_q[wr_ptr_q] <= imem_rdata;
      fq_pc4_q[wr_ptr_q]   <= pc_plus_4;
    end
  end

  // Head of queue drives decode; zeros are shown while the queue is empty.
  always_comb begin
    imem_addr       = pc_q[IMEM_AW+1:2];
    if_id_valid     = head_valid;
    fq_count        = count_q;
    if_id_instr     = 32'h0000_0000;
    if_id_pc_plus_4 = 32'h0000_0000;
    if (head_valid) begin
      if_id_instr     = fq_instr_q[rd_ptr_q];
      if_id_pc_plus_4 = fq_pc4_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_q.sv
// tb_instr_fetch_q: directed test of the fetch queue with an address-tagged
// instruction memory. Inputs change 1 ns after a rising edge; outputs are
// checked at the same point, after the state update from that edge settles.
module tb_instr_fetch_q;

  localparam int IMEM_AW  = 6;
  localparam int FQ_DEPTH = 4;

  logic         clk;
  logic         reset;
  logic         pc_src;
  logic [31:0]  pc_branch;
  logic         jump;
  logic [31:0]  pc_jump;
  logic         stall_id;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]  imem_rdata;
  logic         if_id_valid;
  logic [31:0]  if_id_instr;
  logic [31:0]  if_id_pc_plus_4;
  logic [2:0]   fq_count;

  int checks = 0;
  int errors = 0;

  instr_fetch_q #(
    .IMEM_AW (IMEM_AW),
    .FQ_DEPTH(FQ_DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src         (pc_src),
    .pc_branch      (pc_branch),
    .jump           (jump),
    .pc_jump        (pc_jump),
    .stall_id       (stall_id),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus_4(if_id_pc_plus_4),
    .fq_count       (fq_count)
  );

  // Instruction memory: each word carries its own word address as a tag.
  assign imem_rdata = 32'h1357_0000 | {26'b0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected instruction word for a given fetch PC (6-bit word address).
  function automatic logic [31:0] tagOf(input logic [31:0] pc);
    return 32'h1357_0000 | {26'b0, pc[7:2]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic exp_valid,
                           input logic [31:0] exp_pc4, input logic [31:0] exp_instr,
                           input int exp_count);
    checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, exp_valid});
    checkOutput({tag, ".pc4"},   if_id_pc_plus_4, exp_pc4);
    checkOutput({tag, ".instr"}, if_id_instr, exp_instr);
    checkOutput({tag, ".count"}, {29'b0, fq_count}, exp_count);
  endtask

  // Drive one cycle of inputs, let the edge happen, land 1 ns after it.
  task automatic applyStimulus(input logic rst, input logic stall,
                               input logic br, input logic [31:0] br_tgt,
                               input logic jmp, input logic [31:0] jmp_tgt);
    reset     = rst;
    stall_id  = stall;
    pc_src    = br;
    pc_branch = br_tgt;
    jump      = jmp;
    pc_jump   = jmp_tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; stall_id = 1'b0; pc_src = 1'b0; jump = 1'b0;
    pc_branch = '0; pc_jump = '0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkHead("reset", 0, 32'h0, 32'h0, 0);
    checkOutput("reset.addr", {26'b0, imem_addr}, 32'd0);

    // Streaming: one push and one pop per cycle, head advances by 4
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkHead($sformatf("stream%0d", k), 1, 32'(4 * k), tagOf(32'(4 * (k - 1))), 1);
    end

    // Mid-stream reset empties the queue and returns the PC to 0
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkHead("midreset", 0, 32'h0, 32'h0, 0);
    checkOutput("midreset.addr", {26'b0, imem_addr}, 32'd0);

    // Stall for 6 cycles: queue fills to 4 and the PC freezes at 16
    begin
      int exp_cnt [6] = '{1, 2, 3, 4, 4, 4};
      for (int k = 0; k < 6; k++) begin
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput($sformatf("stall%0d.count", k), {29'b0, fq_count}, exp_cnt[k]);
      end
    end
    checkHead("stallhold", 1, 32'h4, tagOf(32'h0), 4);
    checkOutput("stallhold.addr", {26'b0, imem_addr}, 32'd4);

    // Full queue released: pop and push together, count stays 4, no gaps
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkHead($sformatf("fullflow%0d", k), 1, 32'(4 * (k + 1)), tagOf(32'(4 * k)), 4);
    end
    checkOutput("fullflow.addr", {26'b0, imem_addr}, 32'd8);

    // Branch redirect with 3 entries queued (stall ignored on redirect)
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pre_branch.count", {29'b0, fq_count}, 32'd3);
    applyStimulus(0, 1, 1, 32'h40, 0, 0);
    checkHead("branch.flush", 0, 32'h0, 32'h0, 0);
    checkOutput("branch.addr", {26'b0, imem_addr}, 32'd16);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("branch.first", 1, 32'h44, tagOf(32'h40), 1);

    // Jump beats branch in the same cycle; jump target is word-aligned
    applyStimulus(0, 0, 1, 32'h20, 1, 32'h83);
    checkHead("jump.flush", 0, 32'h0, 32'h0, 0);
    checkOutput("jump.addr", {26'b0, imem_addr}, 32'd32);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("jump.first", 1, 32'h84, tagOf(32'h80), 1);

    // PC wrap at the top of the address space
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
    checkHead("wrap.flush", 0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("wrap0", 1, 32'hFFFF_FFFC, tagOf(32'hFFFF_FFF8), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("wrap1", 1, 32'h0000_0000, tagOf(32'hFFFF_FFFC), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("wrap2", 1, 32'h0000_0004, tagOf(32'h0), 1);

    // Reset in the middle of the stream, then restart from 0
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkHead("wrapreset", 0, 32'h0, 32'h0, 0);
    checkOutput("wrapreset.addr", {26'b0, imem_addr}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("restart", 1, 32'h4, tagOf(32'h0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_q.md
INSTR_FETCH_Q -- requirements
Module: instr_fetch_q

Interface
REQ-001 Parameter IMEM_AW, default 6: instruction-memory word-address width.
REQ-002 Parameter FQ_DEPTH, default 4: fetch-queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; word aligned.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc_src  input  1  taken-branch redirect request.
REQ-007 pc_branch  input  32  branch target.
REQ-008 jump  input  1  jump redirect request.
REQ-009 pc_jump  input  32  jump target.
REQ-010 stall_id  input  1  decode cannot accept this cycle; active-high.
REQ-011 imem_addr  output  IMEM_AW  word address to instruction memory, equal to pc[IMEM_AW+1:2].
REQ-012 imem_rdata  input  32  combinational instruction read data for imem_addr.
REQ-013 if_id_valid  output  1  queue head holds a valid instruction.
REQ-014 if_id_instr  output  32  head instruction; 32'h0000_0000 when if_id_valid=0.
REQ-015 if_id_pc_plus_4  output  32  head instruction's PC+4; 32'h0 when if_id_valid=0.
REQ-016 fq_count  output  $clog2(FQ_DEPTH)+1  current queue occupancy.

Function
REQ-017 Redirect active when pc_src=1 or jump=1; target = pc_jump if jump=1, else pc_branch (jump has priority).
REQ-018 Target is word-aligned by forcing bits [1:0] to 0 before it is loaded into the PC.
REQ-019 Redirect cycle: PC <= target; queue emptied (count <= 0); no push; no pop is counted; stall_id ignored.
REQ-020 Pop = if_id_valid & ~stall_id & ~redirect; pop retires the head entry at the clock edge.
REQ-021 Push = ~redirect & (count < FQ_DEPTH | pop); push writes {pc+4, imem_rdata} at the tail, and PC <= PC+4.
REQ-022 No push: PC holds its value and imem_addr stays stable.
REQ-023 Simultaneous push and pop when full: both occur; count stays FQ_DEPTH.
REQ-024 Simultaneous push and pop when count=1: the new entry becomes head; count stays 1.
REQ-025 if_id_valid = (count != 0); head outputs are combinational from the head entry and hold while stall_id=1.
REQ-026 Pointers wrap modulo FQ_DEPTH; count never exceeds FQ_DEPTH or underflows below 0.
REQ-027 PC+4 arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-028 Latency: instruction fetched in cycle N is visible at if_id_* in cycle N+1 if the queue was empty.
REQ-029 Redirect latency: redirect in cycle N -> target fetched in N+1 -> if_id_valid=1 with target instruction in N+2.
REQ-030 Queue storage needs no reset; only pointers, count and PC are reset.

Reset
REQ-031 reset=1 has priority over redirect, push and pop.
REQ-032 On reset: PC <= RESET_PC, count <= 0, read and write pointers <= 0; the next cycle shows if_id_valid=0, if_id_instr=0, if_id_pc_plus_4=0, fq_count=0.
REQ-033 Reset asserted mid-operation discards all queued entries; fetch restarts at RESET_PC on the first cycle after reset deasserts.

Verification
REQ-034 Reset, then stall_id=0 and imem returns addr-tagged words -> if_id_valid rises one cycle after first fetch; if_id_pc_plus_4 = 4, 8, 12, ... each cycle.
REQ-035 stall_id=1 held 6 cycles, FQ_DEPTH=4 -> fq_count = 1, 2, 3, 4, 4, 4; PC frozen at 16; head stays instr@0 with pc_plus_4=4.
REQ-036 Queue full, then stall_id=0 -> one pop and one push per cycle; fq_count stays 4; in-order output with no gaps.
REQ-037 pc_src=1, pc_branch=32'h40 with 3 entries queued -> next cycle if_id_valid=0, fq_count=0; following cycle if_id_pc_plus_4=32'h44.
REQ-038 jump=1, pc_jump=32'h83 and pc_src=1, pc_branch=32'h20 in the same cycle -> PC loads 32'h80; first output pc_plus_4=32'h84.
REQ-039 PC preset near 32'hFFFF_FFF8 by jump -> outputs pc_plus_4 = FFFF_FFFC, 0000_0000, 0000_0004; reset asserted mid-stream -> empty queue and PC=RESET_PC.
